// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   state_t     : FSM state encodings (2'b11 is unreachable and recovers to RUN)
//   ctrl_out_t  : bundle of the Mealy control outputs
//   REG_ZERO    : architectural zero register (never a real dependency)
//   WAIT_LIMIT  : memory-wait timer value that forces a timeout
//   CNT_MAX     : saturation value of the performance counters
//   sat_inc     : saturating increment for the 16-bit counters
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'b00,
    ST_RUN      = 2'b01,
    ST_MEM_WAIT = 2'b10,
    ST_ILLEGAL  = 2'b11
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic ctrl_zero;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_flush;
    logic ex_flush;
  } ctrl_out_t;

  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam logic [7:0]  WAIT_LIMIT = 8'd255;
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_lud.sv
// load_use_detect: combinational load-use hazard comparator.
//   ex_memread : ID/EX instruction is a load
//   ex_rt      : destination of that load
//   id_rs/id_rt: source fields of the instruction in ID
//   lu         : ID instruction needs the load result next cycle
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       lu
);

  // A load into r0 writes nothing, so it can never create a dependency.
  assign lu = ex_memread && (ex_rt != REG_ZERO) &&
              ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: pipeline enable/flush controller with memory-wait FSM.
// Inputs : clk, rst (async, active-high), id_rs/id_rt/ex_rt/ex_memread
//          (load-use detection), pcsrc/jump (redirects), mem_req/mem_ready.
// Outputs: pc_write, if_id_write, ctrl_zero, id_ex_write, ex_mem_write,
//          if_flush, ex_flush (Mealy), state (debug view of the FSM),
//          stall_cnt/flush_cnt (saturating), mem_timeout (sticky).
//
// Memory handshake: mem_req is held by MEM while it has an access in flight;
// the access completes in the cycle where mem_req and mem_ready are both high.
// mem_ready without a request in RUN has no effect; in MEM_WAIT mem_ready alone
// ends the wait.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_memread,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        ctrl_zero,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        if_flush,
  output logic        ex_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_timeout
);

  state_t     state_r;
  state_t     state_nx;
  ctrl_out_t  ctl;
  logic       init_cnt;
  logic [7:0] wait_timer;
  logic       lu;
  logic       wait_start;
  logic       timeout_hit;

  load_use_detect u_load_use_detect (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .lu         (lu)
  );

  assign wait_start  = (state_r == ST_RUN) && mem_req && !mem_ready;
  // Timer counts the MEM_WAIT cycles already spent; the cycle that would make
  // it reach WAIT_LIMIT is the last one we are willing to wait.
  assign timeout_hit = (state_r == ST_MEM_WAIT) && !mem_ready &&
                       (wait_timer == (WAIT_LIMIT - 8'd1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_INIT;
    else     state_r <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_INIT:     state_nx = init_cnt ? ST_RUN : ST_INIT;
      ST_RUN:      state_nx = wait_start ? ST_MEM_WAIT : ST_RUN;
      ST_MEM_WAIT: state_nx = (mem_ready || timeout_hit) ? ST_RUN : ST_MEM_WAIT;
      default:     state_nx = ST_RUN;
    endcase
  end

  // Output decode (Mealy). Priority in RUN: memory wait, load-use, branch, jump.
  always_comb begin
    ctl = '0;
    case (state_r)
      ST_INIT: begin
        ctl.ctrl_zero    = 1'b1;
        ctl.id_ex_write  = 1'b1;
        ctl.ex_mem_write = 1'b1;
        ctl.if_flush     = 1'b1;
        ctl.ex_flush     = 1'b1;
      end
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          ctl = '0;
        end else if (lu) begin
          // Hold PC and IF/ID, inject a bubble; redirects wait a cycle.
          ctl.ctrl_zero    = 1'b1;
          ctl.id_ex_write  = 1'b1;
          ctl.ex_mem_write = 1'b1;
        end else begin
          ctl.pc_write     = 1'b1;
          ctl.if_id_write  = 1'b1;
          ctl.id_ex_write  = 1'b1;
          ctl.ex_mem_write = 1'b1;
          ctl.if_flush     = pcsrc || jump;
          ctl.ex_flush     = pcsrc;
        end
      end
      ST_MEM_WAIT: begin
        // The completing cycle behaves like an ordinary RUN cycle.
        if (mem_ready) begin
          ctl.pc_write     = 1'b1;
          ctl.if_id_write  = 1'b1;
          ctl.id_ex_write  = 1'b1;
          ctl.ex_mem_write = 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: freeze and bubble for the single recovery cycle.
        ctl.ctrl_zero = 1'b1;
      end
    endcase
  end

  assign pc_write     = ctl.pc_write;
  assign if_id_write  = ctl.if_id_write;
  assign ctrl_zero    = ctl.ctrl_zero;
  assign id_ex_write  = ctl.id_ex_write;
  assign ex_mem_write = ctl.ex_mem_write;
  assign if_flush     = ctl.if_flush;
  assign ex_flush     = ctl.ex_flush;
  assign state        = state_r;

  // INIT length counter and memory-wait timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt   <= 1'b0;
      wait_timer <= 8'd0;
    end else begin
      init_cnt <= (state_r == ST_INIT) ? ~init_cnt : 1'b0;
      if (wait_start)
        wait_timer <= 8'd0;
      else if ((state_r == ST_MEM_WAIT) && (wait_timer != WAIT_LIMIT))
        wait_timer <= wait_timer + 8'd1;
    end
  end

  // Performance counters and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt   <= 16'd0;
      flush_cnt   <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      if (((state_r == ST_RUN) || (state_r == ST_MEM_WAIT)) && !ctl.pc_write)
        stall_cnt <= sat_inc(stall_cnt);
      if ((state_r == ST_RUN) && ctl.if_flush)
        flush_cnt <= sat_inc(flush_cnt);
      if (timeout_hit)
        mem_timeout <= 1'b1;
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL provide the following ports (name, direction, width, meaning):
- clk  in  1  single system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- ex_rt  in  5  destination rt of the instruction in ID/EX.
- ex_memread  in  1  the ID/EX instruction is a load.
- pcsrc  in  1  branch resolved taken in ID.
- jump  in  1  jump decoded in ID.
- mem_req  in  1  MEM stage is performing a data access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- ctrl_zero  out  1  zero the control bits into ID/EX (bubble).
- id_ex_write, ex_mem_write  out  1 each  pipeline register enables.
- if_flush, ex_flush  out  1 each  flush IF/ID, flush ID/EX.
- state  out  2  current FSM state.
- stall_cnt, flush_cnt  out  16 each  saturating performance counters.
- mem_timeout  out  1  sticky memory-wait timeout flag.
REQ-002 Clock and reset: one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-003 FSM states SHALL be INIT=2'b00, RUN=2'b01, MEM_WAIT=2'b10; 2'b11 is illegal and SHALL transition to RUN.
REQ-004 INIT SHALL last exactly 2 cycles after rst deasserts, tracked by a 1-bit counter. During INIT: pc_write=0, if_id_write=0, if_flush=1, ex_flush=1, ctrl_zero=1, id_ex_write=1, ex_mem_write=1. INIT then transitions to RUN.
REQ-005 Load-use hazard (lu) SHALL be defined as ex_memread & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt).
REQ-006 Outputs SHALL be Mealy (combinational from state and inputs). Priority in RUN: memory wait > lu > redirect > normal.
REQ-007 RUN with mem_req & !mem_ready: all four write enables 0, flushes 0, ctrl_zero 0; next state MEM_WAIT.
REQ-008 RUN with lu (no memory wait): pc_write=0, if_id_write=0, ctrl_zero=1, other enables 1, if_flush=ex_flush=0. pcsrc/jump SHALL be ignored this cycle. State stays RUN.
REQ-009 RUN with pcsrc (no wait, no lu): if_flush=1, ex_flush=1, all enables 1.
REQ-010 RUN with jump only (no wait, no lu, no pcsrc): if_flush=1, ex_flush=0, all enables 1.
REQ-011 RUN otherwise: all enables 1, flushes 0, ctrl_zero 0.
REQ-012 MEM_WAIT: all enables 0, flushes 0; lu/pcsrc/jump ignored. On mem_ready the state returns to RUN and that cycle's outputs equal those of RUN-normal.
REQ-013 An 8-bit wait timer SHALL clear on entry to MEM_WAIT and increment each cycle in MEM_WAIT. On reaching 255, mem_timeout SHALL set (sticky until rst) and the state SHALL force to RUN.
REQ-014 stall_cnt SHALL increment each cycle pc_write=0 while in RUN or MEM_WAIT, saturating at 16'hFFFF.
REQ-015 flush_cnt SHALL increment each cycle if_flush=1 in RUN, saturating at 16'hFFFF.
REQ-016 Counters and the timer SHALL update only on the clk rising edge. Illegal state recovery SHALL take 1 cycle.

Reset
REQ-017 rst asserted SHALL immediately force: state=INIT, INIT counter=0, wait timer=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
REQ-018 Reset asserted mid-MEM_WAIT or mid-stall SHALL abandon the operation with no residual effect; INIT restarts on deassertion.

Structure
REQ-019 A shared package SHALL hold the state encodings, REG_ZERO=5'd0, WAIT_LIMIT=8'd255, and CNT_MAX=16'hFFFF.
REQ-020 The lu comparator SHALL be a combinational sub-module named load_use_detect. FSM, counters and output decode SHALL remain in pipeline_ctrl.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Reset release: after rst falls, state=INIT for 2 cycles with if_flush=1 and pc_write=0, then state=RUN with pc_write=1.
- Load-use: ex_memread=1, ex_rt=5, id_rs=5 -> one cycle with pc_write=0, if_id_write=0, ctrl_zero=1, stall_cnt+1. Repeating the check with ex_rt=0 -> no stall.
- Load-use with simultaneous pcsrc=1 -> if_flush=0 and ctrl_zero=1. Next cycle, with lu cleared and pcsrc=1 -> if_flush=ex_flush=1 and flush_cnt+1.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles -> state=MEM_WAIT, all enables 0, stall_cnt+=3 (+1 for the entry cycle); on mem_ready=1 -> state=RUN.
- Timeout: mem_req=1 and mem_ready held 0 -> mem_timeout=1 after 255 MEM_WAIT cycles and state=RUN; the flag stays set until rst.
- Saturation: preload flush_cnt to 16'hFFFE via stimulus and issue 3 jumps -> flush_cnt=16'hFFFF. Asserting rst mid-MEM_WAIT -> state=INIT immediately and all counters 0.
